// File: rtl/debayer_pkg.sv
// Shared constants and state encoding for the debayer sequencer.
package debayer_pkg;

  localparam int SIZE_X = 640;
  localparam int SIZE_Y = 480;
  localparam int ADDR_W = 19;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_VSYNC,
    S_ACTIVE,
    S_FLUSH,
    S_DONE
  } state_e;

endpackage

// File: rtl/debayer_if.sv
// Sensor input and debayer/framebuffer control bundle.
interface debayer_if;
  import debayer_pkg::*;

  logic              enable;
  logic              vsync;
  logic              pix_valid;
  logic [7:0]        raw_in;
  logic              deb_rst;
  logic              deb_en;
  logic [ADDR_W-1:0] deb_addr;
  logic [7:0]        deb_raw;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              frame_done;
  logic              busy;
  logic              err_short;

  modport master (
    output enable, vsync, pix_valid, raw_in,
    input  deb_rst, deb_en, deb_addr, deb_raw,
    input  wr_en, wr_addr, frame_done, busy, err_short
  );

  modport slave (
    input  enable, vsync, pix_valid, raw_in,
    output deb_rst, deb_en, deb_addr, deb_raw,
    output wr_en, wr_addr, frame_done, busy, err_short
  );

endinterface

// File: rtl/debayer_edge_detect.sv
// Rising-edge detector against a one-cycle registered copy.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;
  logic d_d;

  assign d_d  = d;
  assign rise = d & ~d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d_d;
  end

endmodule

// File: rtl/debayer_seq.sv
// Frame sequencer feeding a raw sample stream through a fixed-latency
// debayer and steering its RGB output into a framebuffer.
module debayer_seq #(
  parameter int SIZE_X = debayer_pkg::SIZE_X,
  parameter int SIZE_Y = debayer_pkg::SIZE_Y,
  parameter int LAT    = SIZE_X + 1
) (
  input logic      clock,
  input logic      reset,
  debayer_if.slave io
);
  import debayer_pkg::*;

  localparam int NPIX = SIZE_X * SIZE_Y;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W-1:0] LAT_C = ADDR_W'(LAT);

  if (NPIX > (1 << ADDR_W)) begin : g_size_chk
    $error("SIZE_X*SIZE_Y exceeds the 19-bit pixel index");
  end

  state_e            state_q, state_d;
  logic [1:0]        sync_q, sync_d;
  logic [ADDR_W-1:0] in_cnt_q, in_cnt_d;
  logic [ADDR_W-1:0] out_cnt_q, out_cnt_d;
  logic [ADDR_W-1:0] en_cnt_q, en_cnt_d;
  logic [ADDR_W-1:0] fl_cnt_q, fl_cnt_d;
  logic [ADDR_W-1:0] deb_addr_q, deb_addr_d;
  logic [7:0]        deb_raw_q, deb_raw_d;
  logic              deb_rst_q, deb_rst_d;
  logic              deb_en_q, deb_en_d;
  logic              wr_en_q, wr_en_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              vs_rise;
  logic              busy;

  edge_detect u_vs (
    .clk   (clock),
    .rst_n (reset),
    .d     (io.vsync),
    .rise  (vs_rise)
  );

  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[0], 1'b1};
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    fl_cnt_d   = fl_cnt_q;
    deb_addr_d = deb_addr_q;
    deb_raw_d  = '0;
    deb_rst_d  = 1'b0;
    deb_en_d   = 1'b0;
    done_d     = 1'b0;
    err_d      = err_q;
    // en_cnt saturates at LAT: only the threshold matters
    en_cnt_d = (deb_en_q && en_cnt_q < LAT_C) ? en_cnt_q + 1'b1 : en_cnt_q;
    wr_en_d  = deb_en_q && (en_cnt_q >= LAT_C);
    if (wr_en_q && out_cnt_q != LAST) out_cnt_d = out_cnt_q + 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (io.enable && sync_q[1]) begin
          state_d = S_WAIT_VSYNC;
          err_d   = 1'b0;
        end
      end
      S_WAIT_VSYNC, S_ACTIVE: begin
        if (vs_rise) begin
          if (state_q == S_ACTIVE) err_d = 1'b1;
          state_d    = S_ACTIVE;
          deb_rst_d  = 1'b1;
          in_cnt_d   = '0;
          out_cnt_d  = '0;
          en_cnt_d   = '0;
          wr_en_d    = 1'b0;
          deb_addr_d = '0;
        end else if (state_q == S_ACTIVE && io.pix_valid) begin
          deb_en_d   = 1'b1;
          deb_raw_d  = io.raw_in;
          deb_addr_d = in_cnt_q;
          in_cnt_d   = in_cnt_q + 1'b1;
          if (in_cnt_q == LAST) begin
            state_d  = S_FLUSH;
            fl_cnt_d = '0;
          end
        end
      end
      S_FLUSH: begin
        fl_cnt_d = fl_cnt_q + 1'b1;
        // one extra idle cycle lets the last write retire before DONE
        if (fl_cnt_q < LAT_C) begin
          deb_en_d   = 1'b1;
          deb_addr_d = in_cnt_q;
          in_cnt_d   = in_cnt_q + 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = io.enable ? S_WAIT_VSYNC : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      sync_q     <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      en_cnt_q   <= '0;
      fl_cnt_q   <= '0;
      deb_addr_q <= '0;
      deb_raw_q  <= '0;
      deb_rst_q  <= 1'b0;
      deb_en_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      en_cnt_q   <= en_cnt_d;
      fl_cnt_q   <= fl_cnt_d;
      deb_addr_q <= deb_addr_d;
      deb_raw_q  <= deb_raw_d;
      deb_rst_q  <= deb_rst_d;
      deb_en_q   <= deb_en_d;
      wr_en_q    <= wr_en_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    busy = (state_q == S_WAIT_VSYNC) ||
           (state_q == S_ACTIVE) ||
           (state_q == S_FLUSH);
  end

  assign io.deb_rst    = deb_rst_q;
  assign io.deb_en     = deb_en_q;
  assign io.deb_addr   = deb_addr_q;
  assign io.deb_raw    = deb_raw_q;
  assign io.wr_en      = wr_en_q;
  assign io.wr_addr    = out_cnt_q;
  assign io.frame_done = done_q;
  assign io.busy       = busy;
  assign io.err_short  = err_q;

endmodule
